// File: rtl/answer_entry_if.sv
// Answer handshake between the entry stage and the game FSM.
// Master side presents a latched answer; slave side accepts it.
interface answer_entry_if #(
    parameter int WIDTH = 8
);
    logic             ans_valid;
    logic             ans_ready;
    logic [WIDTH-1:0] ans_data;

    modport master (
        output ans_valid,
        output ans_data,
        input  ans_ready
    );

    modport slave (
        input  ans_valid,
        input  ans_data,
        output ans_ready
    );
endinterface

// File: rtl/answer_entry.sv
// Input conditioning for the mental-math game: sync + debounce of the
// answer switches and submit button, one latched answer per enable window.
module answer_entry #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  switch_raw,
    input  logic              submit_raw,
    input  logic              enable,
    answer_entry_if.master    ans,
    output logic [WIDTH-1:0]  sw_stable,
    output logic              armed,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HOLD,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sw_s1_q, sw_s1_d;
    logic [WIDTH-1:0] sw_s2_q, sw_s2_d;
    logic [WIDTH-1:0] sw_cand_q, sw_cand_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic [WIDTH-1:0] sw_stable_q, sw_stable_d;

    logic             sub_s1_q, sub_s1_d;
    logic             sub_s2_q, sub_s2_d;
    logic             sub_cand_q, sub_cand_d;
    logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
    logic             sub_stable_q, sub_stable_d;
    logic             sub_prev_q, sub_prev_d;

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;
    logic             press;

    always_comb begin
        sw_s1_d     = switch_raw;
        sw_s2_d     = sw_s1_q;
        sw_cand_d   = sw_cand_q;
        sw_cnt_d    = sw_cnt_q;
        sw_stable_d = sw_stable_q;
        if (sw_s2_q != sw_cand_q) begin
            sw_cand_d = sw_s2_q;
            sw_cnt_d  = '0;
        end else if (sw_cnt_q < CNT_MAX) begin
            sw_cnt_d = sw_cnt_q + CNT_W'(1);
        end else begin
            sw_stable_d = sw_cand_q;
        end
    end

    always_comb begin
        sub_s1_d     = submit_raw;
        sub_s2_d     = sub_s1_q;
        sub_cand_d   = sub_cand_q;
        sub_cnt_d    = sub_cnt_q;
        sub_stable_d = sub_stable_q;
        if (sub_s2_q != sub_cand_q) begin
            sub_cand_d = sub_s2_q;
            sub_cnt_d  = '0;
        end else if (sub_cnt_q < CNT_MAX) begin
            sub_cnt_d = sub_cnt_q + CNT_W'(1);
        end else begin
            sub_stable_d = sub_cand_q;
        end
    end

    // Rising edge of the debounced button; history tracks in every state
    assign press      = sub_stable_q & ~sub_prev_q;
    assign sub_prev_d = sub_stable_q;

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (!enable) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = ARMED;
                    overrun_d = 1'b0;
                end
                ARMED: begin
                    if (press) begin
                        data_d  = sw_stable_q;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (press) begin
                        overrun_d = 1'b1;
                    end
                    if (ans.ans_ready) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q      <= '0;
            sw_s2_q      <= '0;
            sw_cand_q    <= '0;
            sw_cnt_q     <= '0;
            sw_stable_q  <= '0;
            sub_s1_q     <= 1'b0;
            sub_s2_q     <= 1'b0;
            sub_cand_q   <= 1'b0;
            sub_cnt_q    <= '0;
            sub_stable_q <= 1'b0;
            sub_prev_q   <= 1'b0;
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            data_q       <= '0;
            overrun_q    <= 1'b0;
        end else begin
            sw_s1_q      <= sw_s1_d;
            sw_s2_q      <= sw_s2_d;
            sw_cand_q    <= sw_cand_d;
            sw_cnt_q     <= sw_cnt_d;
            sw_stable_q  <= sw_stable_d;
            sub_s1_q     <= sub_s1_d;
            sub_s2_q     <= sub_s2_d;
            sub_cand_q   <= sub_cand_d;
            sub_cnt_q    <= sub_cnt_d;
            sub_stable_q <= sub_stable_d;
            sub_prev_q   <= sub_prev_d;
            state_q      <= state_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            overrun_q    <= overrun_d;
        end
    end

    assign ans.ans_valid = valid_q;
    assign ans.ans_data  = data_q;
    assign sw_stable     = sw_stable_q;
    assign armed         = (state_q == ARMED);
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_answer_entry.sv
// Directed bench for answer_entry: debounce latency, handshake,
// overrun, abort and reset behaviour with DEBOUNCE_CYCLES=4.
module tb_answer_entry;

    logic       clk;
    logic       rst;
    logic [7:0] switch_raw;
    logic       submit_raw;
    logic       enable;
    logic [7:0] sw_stable;
    logic       armed;
    logic       overrun;

    int n_chk;
    int n_err;
    int lat;

    answer_entry_if #(.WIDTH(8)) ans_if ();

    answer_entry #(
        .WIDTH          (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .switch_raw(switch_raw),
        .submit_raw(submit_raw),
        .enable    (enable),
        .ans       (ans_if),
        .sw_stable (sw_stable),
        .armed     (armed),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Count edges from now until ans_valid rises (bounded)
    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (ans_if.ans_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_overrun(output int cyc);
        cyc = 0;
        while (overrun !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        switch_raw = 8'h0D;
        submit_raw = 1'b0;
        enable = 1'b0;
        ans_if.ans_ready = 1'b0;

        // Reset state and power-up debounce latency
        tick(3);
        chk("rst_valid", ans_if.ans_valid, 0);
        chk("rst_stable", sw_stable, 0);
        chk("rst_armed", armed, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        tick(6);
        chk("pwr_edge6", sw_stable, 8'h00);
        tick();
        chk("pwr_edge7", sw_stable, 8'h0D);

        // Bouncing bit0 never reaches sw_stable
        switch_raw = 8'h0C;
        tick(10);
        chk("settle_0c", sw_stable, 8'h0C);
        for (int k = 0; k < 6; k++) begin
            switch_raw = (k % 2 == 0) ? 8'h0D : 8'h0C;
            tick(2);
            chk("bounce", sw_stable, 8'h0C);
        end
        switch_raw = 8'h0D;
        tick(6);
        chk("bounce_edge6", sw_stable, 8'h0C);
        tick();
        chk("bounce_edge7", sw_stable, 8'h0D);

        // Normal handshake with answer 23
        switch_raw = 8'd23;
        tick(8);
        enable = 1'b1;
        tick();
        chk("armed_on", armed, 1);
        submit_raw = 1'b1;
        wait_valid(lat);
        chk("press_lat", lat, 8);
        chk("hold_data", ans_if.ans_data, 8'd23);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) submit_raw = 1'b0;
            tick();
            chk("hold_valid", ans_if.ans_valid, 1);
            chk("hold_data23", ans_if.ans_data, 8'd23);
        end
        ans_if.ans_ready = 1'b1;
        tick();
        chk("ack_valid", ans_if.ans_valid, 0);
        chk("ack_armed", armed, 0);
        ans_if.ans_ready = 1'b0;
        tick(10);
        submit_raw = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        chk("done_novalid", ans_if.ans_valid, 0);
        chk("done_noovr", overrun, 0);
        chk("data_kept", ans_if.ans_data, 8'd23);
        submit_raw = 1'b0;
        tick(10);

        // Button held before enable produces no press
        enable = 1'b0;
        tick();
        submit_raw = 1'b1;
        tick(10);
        enable = 1'b1;
        tick();
        chk("held_armed", armed, 1);
        tick(5);
        chk("held_novalid", ans_if.ans_valid, 0);
        submit_raw = 1'b0;
        tick(10);
        switch_raw = 8'd9;
        tick(8);
        submit_raw = 1'b1;
        wait_valid(lat);
        chk("repress_lat", lat, 8);
        chk("repress_data", ans_if.ans_data, 8'd9);
        submit_raw = 1'b0;
        ans_if.ans_ready = 1'b1;
        tick();
        ans_if.ans_ready = 1'b0;
        tick(10);

        // Overrun in HOLD, then abort with ready in the same cycle
        enable = 1'b0;
        tick();
        enable = 1'b1;
        switch_raw = 8'd23;
        tick(8);
        submit_raw = 1'b1;
        wait_valid(lat);
        chk("ovr_data", ans_if.ans_data, 8'd23);
        submit_raw = 1'b0;
        tick(10);
        submit_raw = 1'b1;
        wait_overrun(lat);
        chk("ovr_lat", lat, 8);
        chk("ovr_data23", ans_if.ans_data, 8'd23);
        chk("ovr_valid", ans_if.ans_valid, 1);
        enable = 1'b0;
        ans_if.ans_ready = 1'b1;
        tick();
        chk("abort_valid", ans_if.ans_valid, 0);
        chk("abort_data", ans_if.ans_data, 8'd23);
        chk("abort_ovr", overrun, 1);
        enable = 1'b1;
        ans_if.ans_ready = 1'b0;
        tick();
        chk("reen_armed", armed, 1);
        chk("reen_ovr", overrun, 0);
        submit_raw = 1'b0;
        tick(10);

        // Reset mid-debounce while in HOLD with overrun set
        submit_raw = 1'b1;
        wait_valid(lat);
        chk("rst2_hold", ans_if.ans_valid, 1);
        submit_raw = 1'b0;
        tick(10);
        submit_raw = 1'b1;
        wait_overrun(lat);
        chk("rst2_ovr", overrun, 1);
        submit_raw = 1'b0;
        switch_raw = 8'h55;
        tick(3);
        rst = 1'b1;
        tick();
        chk("rst2_valid", ans_if.ans_valid, 0);
        chk("rst2_stable", sw_stable, 0);
        chk("rst2_overrun", overrun, 0);
        chk("rst2_armed", armed, 0);
        chk("rst2_data", ans_if.ans_data, 0);
        rst = 1'b0;
        tick();
        chk("rst2_rearm", armed, 1);
        tick(5);
        chk("rst2_edge6", sw_stable, 8'h00);
        tick();
        chk("rst2_edge7", sw_stable, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/answer_entry.md
Name: answer_entry

Overview:
Upstream input-conditioning stage for the mental-math game core. It synchronises and debounces the 8 answer switches and the submit push-button, then hands one latched answer per entry window to the game FSM over a valid/ready handshake. It also exposes the live debounced switch value so the game can echo it on LEDs.

Parameters:
WIDTH, 8, width of the switch bus and answer
DEBOUNCE_CYCLES, 4, consecutive identical samples needed before a debounced level changes (>=1)
CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
switch_raw  in  WIDTH  raw asynchronous answer switches
submit_raw  in  1  raw asynchronous submit button, active-high
enable  in  1  entry window open, driven by game FSM
ans_ready  in  1  game FSM accepts the answer
ans_valid  out  1  latched answer available
ans_data  out  WIDTH  latched answer, stable while ans_valid=1
sw_stable  out  WIDTH  live debounced switch value
armed  out  1  high in ARMED state (waiting for press)
overrun  out  1  sticky: a press occurred while an answer was pending

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high. On rst, all of the following are cleared: sync flops, candidates, counters, sw_stable, ans_data, ans_valid, overrun, and press history. FSM goes to IDLE; armed=0.
- Synchroniser: two-flop chain on every switch bit and on submit_raw.
- Switch debounce, one counter for the whole bus:
  - If the sync output differs from the candidate: candidate <= sync output, cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - Else, if candidate differs from sw_stable: sw_stable <= candidate.
  - Latency: a raw change held constant is visible on sw_stable after DEBOUNCE_CYCLES+3 rising edges, counting the edge that captures it into sync stage 1.
  - Any change before then restarts the count.
- Submit debounce: identical logic with its own candidate and counter, producing sub_stable.
- Press event: sub_stable=1 while the previous cycle's sub_stable=0 (single cycle). The history register updates in every state.
- FSM:
  - IDLE: enable=1 -> ARMED.
  - ARMED: armed=1. On a press, ans_data <= sw_stable (the same-cycle value), ans_valid <= 1, go to HOLD.
  - HOLD: ans_valid=1 and ans_data frozen. ans_ready=1 -> ans_valid <= 0, go to DONE. A press here sets overrun <= 1 and leaves ans_data unchanged.
  - DONE: presses are ignored; enable=0 -> IDLE.
  - enable=0 in any state forces IDLE on the next edge, and ans_valid drops on that edge (abort). This has priority over a press or ans_ready in the same cycle.
- overrun is cleared on rst and on the IDLE->ARMED transition.
- A button already held when ARMED is entered produces no press until it is released and pressed again.
- ans_ready is ignored when ans_valid=0.
- ans_data retains its last value after the handshake and after an abort.
- Exactly one answer is delivered per enable window.

Test Plan:
- DEBOUNCE_CYCLES=4. Hold switch_raw=8'h0D through reset release -> sw_stable=0 for 6 edges after release, 8'h0D on edge 7.
- Toggle switch_raw bit0 every 2 cycles for 12 cycles, then settle at 1 -> sw_stable bit0 unchanged during bouncing and set exactly 7 edges after the final toggle.
- enable=1, switches=8'd23, press for 10 cycles with ans_ready=0 for 5 cycles after ans_valid rises -> ans_valid=1, ans_data=23 held throughout. Raise ans_ready -> ans_valid=0 next edge, state DONE; a second press gives no ans_valid and overrun stays 0.
- Hold submit before enable rises -> armed=1 and no ans_valid. Release, wait for debounce, re-press with switches=8'd9 -> ans_valid=1, ans_data=9.
- In HOLD with ans_data=23: press again -> overrun=1 and ans_data stays 23. Drop enable in the same cycle as ans_ready -> ans_valid=0 next edge, IDLE. Re-enable -> overrun=0.
- Assert rst for one cycle mid-debounce and while in HOLD -> next edge gives ans_valid=0, sw_stable=0, overrun=0, armed=0, with enable=1 -> ARMED on the following edge.
